// File: rtl/seq_det_sched_pkg.sv
// seq_det_sched_pkg: shared state encoding and default sizes for the detector scheduler.
package seq_det_sched_pkg;

    typedef enum logic [2:0] {S_IDLE, S_DRST, S_SHIFT, S_DRAIN, S_DONE} state_t;

    localparam int DEF_NREQ   = 2;
    localparam int DEF_WORD_W = 16;
    localparam int DEF_CNT_W  = 5;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_det_sched_rr_arbiter.sv
// rr_arbiter: picks the first asserted request at or after the pointer, wrapping around.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [ID_W-1:0] idx_o,
    output logic            any_o
);

    // Walk from farthest to nearest so the nearest valid requester is written last.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = |req_i;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % NREQ]) begin
                gnt_o = NREQ'(1) << ((int'(ptr_i) + k) % NREQ);
                idx_o = ID_W'((int'(ptr_i) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/seq_det_sched.sv
// seq_det_sched: time-shares one serial sequence detector between NREQ word requesters.
// Optional FIRST_HIT_EN reports the bit index of the first detector hit in each word.
module seq_det_sched
    import seq_det_sched_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int WORD_W = DEF_WORD_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int ID_W   = id_width(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*WORD_W-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               det_rst,
    output logic               det_in,
    input  logic               det_out,
    output logic               busy,
    output logic               res_valid,
    output logic [ID_W-1:0]    res_id,
    output logic [CNT_W-1:0]   res_count,
    output logic [CNT_W-1:0]   res_first
);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d, id_q, id_d, res_id_q, res_id_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [CNT_W-1:0]    idx_q, idx_d, cnt_q, cnt_d, res_count_q, res_count_d;
    logic [WORD_W-1:0]   words [NREQ];
    logic [NREQ-1:0]     gnt;
    logic [ID_W-1:0]     gidx;
    logic                any;
    logic                hit;

    for (genvar g = 0; g < NREQ; g++) begin : g_words
        assign words[g] = req_data[g*WORD_W +: WORD_W];
    end

    rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .req_i(req_valid),
        .ptr_i(ptr_q),
        .gnt_o(gnt),
        .idx_o(gidx),
        .any_o(any)
    );

    // det_out lags det_in by one cycle, so the first SHIFT cycle carries no sample.
    assign hit       = det_out & ((state_q == S_SHIFT && idx_q != '0) || state_q == S_DRAIN);
    assign det_rst   = rst | (state_q == S_DRST);
    assign busy      = state_q != S_IDLE;
    assign res_valid = state_q == S_DONE;
    assign res_id    = res_id_q;
    assign res_count = res_count_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        word_d      = word_q;
        id_d        = id_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q + CNT_W'(hit);
        res_id_d    = res_id_q;
        res_count_d = res_count_q;
        req_ready   = '0;
        det_in      = 1'b0;
        case (state_q)
            S_IDLE: if (any && !rst) begin
                req_ready = gnt;
                word_d    = words[gidx];
                id_d      = gidx;
                ptr_d     = (gidx == ID_W'(NREQ - 1)) ? '0 : gidx + 1'b1;
                state_d   = S_DRST;
            end
            S_DRST: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                det_in  = word_q[0];
                word_d  = word_q >> 1;
                idx_d   = idx_q + 1'b1;
                state_d = (idx_q == CNT_W'(WORD_W - 1)) ? S_DRAIN : S_SHIFT;
            end
            S_DRAIN: begin
                res_id_d    = id_q;
                res_count_d = cnt_d;
                state_d     = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            word_q      <= '0;
            id_q        <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            res_id_q    <= '0;
            res_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            word_q      <= word_d;
            id_q        <= id_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            res_id_q    <= res_id_d;
            res_count_q <= res_count_d;
        end
    end

`ifdef FIRST_HIT_EN
    logic [CNT_W-1:0] first_q, first_d, res_first_q, res_first_d;

    // WORD_W doubles as the "no hit yet" marker; idx_q-1 is the bit whose echo is sampled now.
    always_comb begin
        first_d     = (state_q == S_DRST) ? CNT_W'(WORD_W) :
                      (hit && first_q == CNT_W'(WORD_W)) ? idx_q - 1'b1 : first_q;
        res_first_d = (state_q == S_DRAIN) ? first_d : res_first_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            first_q     <= '0;
            res_first_q <= '0;
        end else begin
            first_q     <= first_d;
            res_first_q <= res_first_d;
        end
    end

    assign res_first = res_first_q;
`else
    assign res_first = '0;
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// tb_seq_det_sched: directed self-checking bench with an echo-stub detector (hits = popcount).
module tb_seq_det_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [31:0] req_data;
    logic [1:0]  req_ready;
    logic        det_rst, det_in, det_out, busy, res_valid;
    logic [0:0]  res_id;
    logic [4:0]  res_count, res_first;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_det_sched dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .det_rst(det_rst), .det_in(det_in), .det_out(det_out),
        .busy(busy), .res_valid(res_valid), .res_id(res_id),
        .res_count(res_count), .res_first(res_first)
    );

    always_ff @(posedge clk) det_out <= det_rst ? 1'b0 : det_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int first_exp(input int v);
`ifdef FIRST_HIT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) break;
        end
    endtask

    task automatic wait_res();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid) break;
        end
    endtask

    // One full transaction from a single requester with cycle-exact checks.
    task automatic do_word(input int r, input logic [15:0] w, input int ec, input int ef);
        @(posedge clk); #1;
        req_valid[r] = 1'b1;
        req_data[r*16 +: 16] = w;
        wait_ready();
        chk("grant", req_ready, 32'(2'b01 << r));
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        @(negedge clk);
        chk("det_rst_pulse", det_rst, 1);
        chk("busy_drst", busy, 1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("det_in_b%0d", i), det_in, w[i]);
        end
        @(negedge clk);
        chk("res_not_early", res_valid, 0);
        @(negedge clk);
        chk("res_valid", res_valid, 1);
        chk("res_id", res_id, r);
        chk("res_count", res_count, ec);
        chk("res_first", res_first, first_exp(ef));
        @(negedge clk);
        chk("res_pulse_end", res_valid, 0);
        chk("res_count_hold", res_count, ec);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            n_cmp++;
            assert (!(busy && req_ready != 2'b00)) else begin
                n_err++;
                $error("FAIL ready_while_busy: observed %b expected 00", req_ready);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_det_rst", det_rst, 1);
        chk("rst_det_in", det_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_count", res_count, 0);
        chk("rst_res_first", res_first, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Both requesters held: round robin 0,1,0,1.
        @(posedge clk); #1;
        req_data = {16'h8010, 16'h000F};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_ready();
            chk("rr_grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
            @(posedge clk); #1;
            if (k == 3) req_valid = 2'b00;
            @(negedge clk);
            chk("rr_ready_pulse", req_ready, 0);
            wait_res();
            chk("rr_res_valid", res_valid, 1);
            chk("rr_res_id", res_id, k % 2);
            chk("rr_res_count", res_count, (k % 2) ? 2 : 4);
            chk("rr_res_first", res_first, first_exp((k % 2) ? 4 : 0));
        end
        @(negedge clk);
        @(negedge clk);
        chk("rr_idle_after", busy, 0);

        do_word(0, 16'b1110101111011001, 11, 0);
        do_word(0, 16'h0000, 0, 16);
        do_word(0, 16'hFFFF, 16, 0);
        do_word(1, 16'h0100, 1, 8);

        // Reset in the middle of a word (SHIFT bit 7).
        @(posedge clk); #1;
        req_valid[0] = 1'b1;
        req_data[15:0] = 16'hFFFF;
        wait_ready();
        chk("abort_grant", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_det_rst", det_rst, 1);
        chk("abort_ready", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_res_count", res_count, 0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        chk("abort_no_res", seen, 0);
        do_word(0, 16'h0F0F, 8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
